// File: rtl/cpu_bus_pkg.sv
// Shared types and defaults for the 6502 bus sequencer.
package cpu_bus_pkg;

    typedef enum logic [2:0] {
        RST_P1,
        RST_P2,
        P1,
        P2,
        HALT
    } bus_state_t;

    localparam int DEF_HALF_PERIOD  = 8;
    localparam int DEF_RESET_CYCLES = 8;
    localparam logic [7:0] RESET_DBI = 8'hFF;

endpackage

// File: rtl/cpu_bus_sequencer.sv
// 6502 phi/reset generator that maps each CPU bus cycle onto one req/ack
// memory transaction, stretching phase 2 until memory answers.
module cpu_bus_sequencer
    import cpu_bus_pkg::*;
#(
    parameter int HALF_PERIOD  = DEF_HALF_PERIOD,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        halt_req,
    output logic        halted,
    output logic        cpu_phi,
    output logic        cpu_res,
    input  logic [15:0] cpu_ab,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_dbo,
    output logic [7:0]  cpu_dbi,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [31:0] cycle_count
);

    localparam int PCW = $clog2(HALF_PERIOD);
    localparam int RCW = $clog2(RESET_CYCLES + 1);
    localparam logic [PCW-1:0] PC_LAST  = PCW'(HALF_PERIOD - 1);
    localparam logic [PCW-1:0] PC_REQ   = PCW'(HALF_PERIOD / 2 - 1);
    localparam logic [RCW-1:0] RST_LAST = RCW'(RESET_CYCLES - 1);

    bus_state_t     state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
    logic           phi_q, phi_d;
    logic           res_q, res_d;
    logic [7:0]     dbi_q, dbi_d;
    logic           req_q, req_d;
    logic           we_q, we_d;
    logic [15:0]    addr_q, addr_d;
    logic [7:0]     wdata_q, wdata_d;
    logic           halted_q, halted_d;
    logic [31:0]    cycle_count_q, cycle_count_d;
    logic           ack_done_q, ack_done_d;
    logic           ack_now;

    // Acks only count while a request is actually outstanding.
    assign ack_now = req_q & mem_ack;

    always_comb begin
        state_d       = state_q;
        pc_d          = (pc_q == PC_LAST) ? pc_q : pc_q + PCW'(1);
        rst_cnt_d     = rst_cnt_q;
        phi_d         = phi_q;
        res_d         = res_q;
        dbi_d         = dbi_q;
        req_d         = req_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        halted_d      = halted_q;
        cycle_count_d = cycle_count_q;
        ack_done_d    = ack_done_q;

        case (state_q)
            RST_P1: begin
                if (pc_q == PC_LAST) begin
                    phi_d   = 1'b1;
                    pc_d    = '0;
                    state_d = RST_P2;
                end
            end
            RST_P2: begin
                if (pc_q == PC_LAST) begin
                    phi_d = 1'b0;
                    pc_d  = '0;
                    if (rst_cnt_q == RST_LAST) begin
                        res_d     = 1'b1;
                        rst_cnt_d = '0;
                        state_d   = P1;
                    end else begin
                        rst_cnt_d = rst_cnt_q + RCW'(1);
                        state_d   = RST_P1;
                    end
                end
            end
            P1: begin
                if (pc_q == PC_LAST) begin
                    addr_d     = cpu_ab;
                    we_d       = ~cpu_rw;
                    phi_d      = 1'b1;
                    pc_d       = '0;
                    ack_done_d = 1'b0;
                    state_d    = P2;
                end
            end
            P2: begin
                // pc saturates above PC_REQ, so the request fires once per cycle.
                if (pc_q == PC_REQ) begin
                    wdata_d = cpu_dbo;
                    req_d   = 1'b1;
                end
                if (ack_now) begin
                    req_d      = 1'b0;
                    ack_done_d = 1'b1;
                    if (!we_q) begin
                        dbi_d = mem_rdata;
                    end
                end
                if ((pc_q == PC_LAST) && (ack_done_q || ack_now)) begin
                    phi_d         = 1'b0;
                    pc_d          = '0;
                    cycle_count_d = cycle_count_q + 32'd1;
                    if (halt_req) begin
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end else begin
                        state_d  = P1;
                    end
                end
            end
            HALT: begin
                pc_d = '0;
                if (!halt_req) begin
                    halted_d = 1'b0;
                    state_d  = P1;
                end
            end
            default: begin
                state_d = RST_P1;
                pc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RST_P1;
            pc_q          <= '0;
            rst_cnt_q     <= '0;
            phi_q         <= 1'b0;
            res_q         <= 1'b0;
            dbi_q         <= RESET_DBI;
            req_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            halted_q      <= 1'b0;
            cycle_count_q <= '0;
            ack_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rst_cnt_q     <= rst_cnt_d;
            phi_q         <= phi_d;
            res_q         <= res_d;
            dbi_q         <= dbi_d;
            req_q         <= req_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            halted_q      <= halted_d;
            cycle_count_q <= cycle_count_d;
            ack_done_q    <= ack_done_d;
        end
    end

    assign cpu_phi     = phi_q;
    assign cpu_res     = res_q;
    assign cpu_dbi     = dbi_q;
    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign halted      = halted_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// Scoreboard bench for cpu_bus_sequencer: expected requests and phi cycles are
// queued by the stimulus and popped by a monitor as the DUT presents them.
module tb_cpu_bus_sequencer;

    localparam int HP = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        halt_req = 1'b0;
    logic        halted;
    logic        cpu_phi;
    logic        cpu_res;
    logic [15:0] cpu_ab = 16'h0000;
    logic        cpu_rw = 1'b1;
    logic [7:0]  cpu_dbo = 8'h00;
    logic [7:0]  cpu_dbi;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic [31:0] cycle_count;

    cpu_bus_sequencer #(.HALF_PERIOD(HP), .RESET_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .halt_req(halt_req), .halted(halted),
        .cpu_phi(cpu_phi), .cpu_res(cpu_res), .cpu_ab(cpu_ab), .cpu_rw(cpu_rw),
        .cpu_dbo(cpu_dbo), .cpu_dbi(cpu_dbi), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
    } req_exp_t;

    typedef struct {
        int          lo;
        int          hi;
        int          rlen;
        logic [7:0]  dbi;
        logic [31:0] cc;
    } cyc_exp_t;

    req_exp_t exp_req_q[$];
    cyc_exp_t exp_cyc_q[$];

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_cc = 32'd0;
    logic [7:0]  exp_dbi = 8'hFF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    // Monitor: measures phi phases and request lengths, pops and compares.
    int   lo_cnt, hi_cnt, req_cnt, lo_meas, rlen_meas;
    logic prev_phi, prev_req, prev_res;

    always @(negedge clk) begin
        if (!rst_n) begin
            lo_cnt = 0; hi_cnt = 0; req_cnt = 0; lo_meas = 0; rlen_meas = 0;
            prev_phi = 1'b0; prev_req = 1'b0; prev_res = 1'b0;
        end else begin
            if (mem_req && !prev_req) begin
                if (exp_req_q.size() == 0) begin
                    chk("unexpected_req", 32'(exp_req_q.size()), 32'd1);
                end else begin
                    req_exp_t e;
                    e = exp_req_q.pop_front();
                    chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                    chk("mem_we", 32'(mem_we), 32'(e.we));
                    chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
                end
                req_cnt = 0;
            end
            if (mem_req) req_cnt++;
            else if (prev_req) rlen_meas = req_cnt;

            if (cpu_phi && !prev_phi) begin
                lo_meas = lo_cnt;
                hi_cnt = 0;
            end
            if (!cpu_phi && prev_phi) begin
                if (prev_res && cpu_res) begin
                    if (exp_cyc_q.size() == 0) begin
                        chk("unexpected_cycle", 32'(exp_cyc_q.size()), 32'd1);
                    end else begin
                        cyc_exp_t c;
                        c = exp_cyc_q.pop_front();
                        chk("phi_low_len", 32'(lo_meas), 32'(c.lo));
                        chk("phi_high_len", 32'(hi_cnt), 32'(c.hi));
                        chk("req_len", 32'(rlen_meas), 32'(c.rlen));
                        chk("cpu_dbi", 32'(cpu_dbi), 32'(c.dbi));
                        chk("cycle_count", cycle_count, c.cc);
                    end
                end
                lo_cnt = 0;
            end
            if (cpu_phi) hi_cnt++;
            else lo_cnt++;
            prev_phi = cpu_phi;
            prev_req = mem_req;
            prev_res = cpu_res;
        end
    end

    task automatic wait_phi(input logic lvl, input string nm);
        int cnt = 0;
        while (cpu_phi !== lvl && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        chk(nm, 32'(cpu_phi), 32'(lvl));
    endtask

    task automatic wait_req(input string nm);
        int cnt = 0;
        while (mem_req !== 1'b1 && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        chk(nm, 32'(mem_req), 32'd1);
    endtask

    // Present a CPU bus cycle during phase 1 and queue what it must produce.
    task automatic setup(input logic [15:0] a, input logic rw, input logic [7:0] d,
                         input logic [7:0] rdata, input int lat, input int lo);
        cyc_exp_t c;
        int hi;
        wait_phi(1'b0, "setup_phi_low");
        cpu_ab = a;
        cpu_rw = rw;
        cpu_dbo = d;
        exp_req_q.push_back('{addr: a, we: ~rw, wdata: d});
        if (rw) exp_dbi = rdata;
        exp_cc = exp_cc + 32'd1;
        hi = (HP / 2 + lat + 1 > HP) ? HP / 2 + lat + 1 : HP;
        c = '{lo: lo, hi: hi, rlen: lat + 1, dbi: exp_dbi, cc: exp_cc};
        exp_cyc_q.push_back(c);
    endtask

    // Act as memory for the cycle: optional spurious ack, then ack after lat.
    task automatic serve(input logic [7:0] rdata, input int lat, input bit spurious,
                         input bit do_halt);
        wait_phi(1'b1, "serve_phi_high");
        if (spurious) begin
            mem_ack = 1'b1;
            mem_rdata = 8'hEE;
            @(negedge clk);
            mem_ack = 1'b0;
        end
        wait_req("serve_req");
        repeat (lat) @(negedge clk);
        mem_ack = 1'b1;
        mem_rdata = rdata;
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        if (do_halt) halt_req = 1'b1;
        wait_phi(1'b0, "serve_phi_fall");
    endtask

    // Release reset and expect cpu_res to rise with a phi fall 128 clocks later.
    task automatic reset_release();
        int n = 0;
        bit bad = 0;
        logic last_phi = 1'b0;
        rst_n = 1'b1;
        while (cpu_res !== 1'b1 && n < 400) begin
            last_phi = cpu_phi;
            @(negedge clk);
            n++;
            if (mem_req !== 1'b0 || cpu_dbi !== 8'hFF) bad = 1;
        end
        chk("res_rise_clock", 32'(n), 32'd128);
        chk("phi_before_res", 32'(last_phi), 32'd1);
        chk("phi_at_res", 32'(cpu_phi), 32'd0);
        chk("quiet_during_reset", 32'(bad), 32'd0);
        exp_cc = 32'd0;
        exp_dbi = 8'hFF;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_phi"}, 32'(cpu_phi), 32'd0);
        chk({tag, "_res"}, 32'(cpu_res), 32'd0);
        chk({tag, "_dbi"}, 32'(cpu_dbi), 32'hFF);
        chk({tag, "_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
        chk({tag, "_cc"}, cycle_count, 32'd0);
    endtask

    initial begin
        int cnt;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset_release();

        // Read at the reset vector, write, then a stretched read with a stray ack.
        setup(16'hFFFC, 1'b1, 8'h00, 8'h34, 1, HP);
        serve(8'h34, 1, 1'b0, 1'b0);
        setup(16'h0200, 1'b0, 8'hA5, 8'h77, 1, HP);
        serve(8'h77, 1, 1'b0, 1'b0);
        setup(16'h1234, 1'b1, 8'h00, 8'h5A, 20, HP);
        serve(8'h5A, 20, 1'b1, 1'b0);

        // Halt requested mid phase 2, held so phi stays low 50 clocks.
        setup(16'h0300, 1'b1, 8'h00, 8'h99, 1, HP);
        serve(8'h99, 1, 1'b0, 1'b1);
        chk("halted_at_fall", 32'(halted), 32'd1);
        setup(16'h0400, 1'b1, 8'h00, 8'hC3, 1, 50);
        repeat (41) @(negedge clk);
        chk("still_halted", 32'(halted), 32'd1);
        halt_req = 1'b0;
        @(negedge clk);
        chk("halted_cleared", 32'(halted), 32'd0);
        cnt = 0;
        while (!cpu_phi && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("release_to_phi_rise", 32'(cnt), 32'd8);
        serve(8'hC3, 1, 1'b0, 1'b0);

        // Reset pulse while a request is outstanding.
        wait_phi(1'b0, "pre_abort_phi_low");
        cpu_ab = 16'h0500;
        cpu_rw = 1'b1;
        cpu_dbo = 8'h00;
        exp_req_q.push_back('{addr: 16'h0500, we: 1'b0, wdata: 8'h00});
        wait_req("abort_req");
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("abort");
        repeat (2) @(negedge clk);
        reset_release();
        setup(16'h0600, 1'b1, 8'h00, 8'h11, 1, HP);
        serve(8'h11, 1, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        chk("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
        chk("cyc_queue_drained", 32'(exp_cyc_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
